// File: rtl/booth_r4_mul_if.sv
// Handshake and operand bundle for the radix-4 Booth multiplier.
// The abort signal exists only when BOOTH_ABORT_EN is defined.
interface booth_r4_mul_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
`ifdef BOOTH_ABORT_EN
  logic                 abort;
`endif
  logic                 signed_mode;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [2*WIDTH-1:0]   z;
  logic                 busy;
  logic                 done;

`ifdef BOOTH_ABORT_EN
  modport master (output start, abort, signed_mode, x, y, input z, busy, done);
  modport slave  (input start, abort, signed_mode, x, y, output z, busy, done);
`else
  modport master (output start, signed_mode, x, y, input z, busy, done);
  modport slave  (input start, signed_mode, x, y, output z, busy, done);
`endif
endinterface

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier, WIDTH/2+1 steps per product, signed or unsigned per op.
// Optional BOOTH_ABORT_EN adds an abort input that cancels a running operation.
module booth_r4_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  booth_r4_mul_if.slave bus
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned AW = WIDTH + 4;
  localparam int unsigned N  = WIDTH / 2 + 1;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_check
    $error("booth_r4_mul: WIDTH must be even and >= 4");
  end

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [CW-1:0]      cnt_q;
  logic [AW-1:0]      mcand_q;
  logic [AW-1:0]      acc_q;
  logic [XW:0]        mplr_q;   // extended multiplier with the implicit y[-1] at bit 0
  logic [2*WIDTH-1:0] z_q;

  logic               x_sign;
  logic               y_sign;
  logic [AW-1:0]      x_ext;
  logic [XW-1:0]      y_ext;
  logic [AW-1:0]      addend;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_nx;
  logic [XW:0]        mplr_nx;

  always_comb begin
    x_sign = bus.signed_mode & bus.x[WIDTH-1];
    y_sign = bus.signed_mode & bus.y[WIDTH-1];
    x_ext  = {{4{x_sign}}, bus.x};
    y_ext  = {{2{y_sign}}, bus.y};
  end

  always_comb begin
    addend = '0;
    case (mplr_q[2:0])
      3'b001, 3'b010: addend = mcand_q;
      3'b011:         addend = mcand_q << 1;
      3'b100:         addend = -(mcand_q << 1);
      3'b101, 3'b110: addend = -mcand_q;
      default:        addend = '0;
    endcase
    sum     = acc_q + addend;
    // Arithmetic shift of the {acc, mplr} pair by two bits.
    acc_nx  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    mplr_nx = {sum[1:0], mplr_q[XW:2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      z_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            mcand_q <= x_ext;
            mplr_q  <= {y_ext, 1'b0};
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
`ifdef BOOTH_ABORT_EN
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else
`endif
          begin
            acc_q  <= acc_nx;
            mplr_q <= mplr_nx;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              // Low 2*WIDTH bits of {acc, mplr} once all multiplier bits are retired.
              z_q     <= {acc_nx[2*WIDTH-XW-1:0], mplr_nx[XW:1]};
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.z    = z_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
